// File: rtl/alu_pkg.sv
// Shared constants for the sequential slice ALU: op codes, flag bit positions,
// controller state encoding and small op-classification helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_SBB = 3'b011,
    OP_AND = 3'b100,
    OP_XOR = 3'b101,
    OP_OR  = 3'b110,
    OP_CMP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_S = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_A = 4;
  localparam int FLAG_P = 2;
  localparam int FLAG_C = 0;

  function automatic logic usesCarryIn(input alu_op_e op);
    return (op == OP_ADC) || (op == OP_SBB);
  endfunction

  function automatic logic isAddOp(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of the sequential ALU; the ALU takes the slave side.
interface alu_seq_if #(
  parameter int W = 16
);
  logic         iStart;
  logic [2:0]   iS;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         iCy;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oY;
  logic [7:0]   oF;

  modport slave (
    input  iStart, iS, iA, iB, iCy,
    output oBusy, oDone, oY, oF
  );

  modport master (
    output iStart, iS, iA, iB, iCy,
    input  oBusy, oDone, oY, oF
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational DATASIZE-bit ALU slice, reused once per BUSY cycle.
// c3 is the carry/borrow out of bit 3 (the half-carry source for the A flag).
module alu_slice
  import alu_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  alu_op_e             op,
  input  logic                dec,
  input  logic [DATASIZE-1:0] a,
  input  logic [DATASIZE-1:0] b,
  input  logic                cin,
  output logic [DATASIZE-1:0] y,
  output logic                cout,
  output logic                c3
);

  localparam int NIBBLES = DATASIZE / 4;

  logic [DATASIZE:0]   sumW;
  logic [DATASIZE:0]   difW;
  logic [4:0]          lowSum;
  logic [4:0]          lowDif;
  logic [4:0]          nib;
  logic [DATASIZE-1:0] bcdY;
  logic                bcdC;
  logic                bcdC3;

  always_comb begin
    sumW   = {1'b0, a} + {1'b0, b} + {{DATASIZE{1'b0}}, cin};
    difW   = {1'b0, a} - {1'b0, b} - {{DATASIZE{1'b0}}, cin};
    lowSum = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    lowDif = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
  end

  // Decimal adjust: any nibble above 9 gets +6 and forwards a decimal carry.
  always_comb begin
    nib   = '0;
    bcdY  = '0;
    bcdC  = cin;
    bcdC3 = 1'b0;
    for (int n = 0; n < NIBBLES; n++) begin
      nib = {1'b0, a[n*4 +: 4]} + {1'b0, b[n*4 +: 4]} + {4'b0, bcdC};
      if (nib > 5'd9) begin
        nib  = nib + 5'd6;
        bcdC = 1'b1;
      end else begin
        bcdC = 1'b0;
      end
      bcdY[n*4 +: 4] = nib[3:0];
      if (n == 0) bcdC3 = bcdC;
    end
  end

  always_comb begin
    y    = '0;
    cout = 1'b0;
    c3   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        if (dec) begin
          y    = bcdY;
          cout = bcdC;
          c3   = bcdC3;
        end else begin
          y    = sumW[DATASIZE-1:0];
          cout = sumW[DATASIZE];
          c3   = lowSum[4];
        end
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        y    = difW[DATASIZE-1:0];
        cout = difW[DATASIZE];
        c3   = lowDif[4];
      end
      OP_AND: begin
        y  = a & b;
        c3 = 1'b1;
      end
      OP_XOR: y = a ^ b;
      OP_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: W = DATASIZE*SLICES operands processed one slice per cycle.
// Define ALU_SEQ_DAA_EN to add the iDec port and decimal-adjusted ADD/ADC.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int SLICES   = 2
) (
  input  logic iClk,
  input  logic iRstN,
`ifdef ALU_SEQ_DAA_EN
  input  logic iDec,
`endif
  alu_seq_if.slave bus
);

  localparam int         W    = DATASIZE * SLICES;
  localparam logic [3:0] LAST = 4'(SLICES - 1);

  state_e              stateQ;
  alu_op_e             opQ;
  logic [W-1:0]        aQ;
  logic [W-1:0]        bQ;
  logic [W-1:0]        resQ;
  logic [W-1:0]        yQ;
  logic [7:0]          fQ;
  logic                carryQ;
  logic                decQ;
  logic                c3Q;
  logic                busyQ;
  logic                doneQ;
  logic [3:0]          idxQ;

  logic                decIn;
  logic [DATASIZE-1:0] sliceA;
  logic [DATASIZE-1:0] sliceB;
  logic [DATASIZE-1:0] sliceY;
  logic                sliceCout;
  logic                sliceC3;
  logic [W-1:0]        resD;
  logic [W-1:0]        aD;
  logic [W-1:0]        bD;
  logic [W-1:0]        yD;
  logic [7:0]          fD;
  logic                aFlagD;

`ifdef ALU_SEQ_DAA_EN
  assign decIn = iDec;
`else
  assign decIn = 1'b0;
`endif

  assign sliceA = aQ[DATASIZE-1:0];
  assign sliceB = bQ[DATASIZE-1:0];

  alu_slice #(.DATASIZE(DATASIZE)) u_slice (
    .op   (opQ),
    .dec  (decQ),
    .a    (sliceA),
    .b    (sliceB),
    .cin  (carryQ),
    .y    (sliceY),
    .cout (sliceCout),
    .c3   (sliceC3)
  );

  // Operands shift right one slice per cycle; A is rotated rather than shifted
  // so the original value is back in place for CMP once all slices are done.
  always_comb begin
    resD   = (resQ >> DATASIZE) | (W'(sliceY) << (W - DATASIZE));
    aD     = (aQ >> DATASIZE) | (W'(sliceA) << (W - DATASIZE));
    bD     = bQ >> DATASIZE;
    aFlagD = (idxQ == 4'd0) ? sliceC3 : c3Q;
    yD     = (opQ == OP_CMP) ? aD : resD;
    fD         = '0;
    fD[FLAG_S] = resD[W-1];
    fD[FLAG_Z] = (resD == '0);
    fD[FLAG_A] = aFlagD;
    fD[FLAG_P] = ~^resD;
    fD[FLAG_C] = sliceCout;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateQ <= ST_IDLE;
      opQ    <= OP_ADD;
      aQ     <= '0;
      bQ     <= '0;
      resQ   <= '0;
      yQ     <= '0;
      fQ     <= '0;
      carryQ <= 1'b0;
      decQ   <= 1'b0;
      c3Q    <= 1'b0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      idxQ   <= '0;
    end else begin
      doneQ <= 1'b0;
      case (stateQ)
        ST_IDLE, ST_DONE: begin
          if (bus.iStart) begin
            stateQ <= ST_BUSY;
            busyQ  <= 1'b1;
            opQ    <= alu_op_e'(bus.iS);
            aQ     <= bus.iA;
            bQ     <= bus.iB;
            resQ   <= '0;
            idxQ   <= '0;
            carryQ <= usesCarryIn(alu_op_e'(bus.iS)) & bus.iCy;
            decQ   <= isAddOp(alu_op_e'(bus.iS)) & decIn;
          end else begin
            stateQ <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          aQ     <= aD;
          bQ     <= bD;
          resQ   <= resD;
          carryQ <= sliceCout;
          idxQ   <= idxQ + 4'd1;
          if (idxQ == 4'd0) c3Q <= sliceC3;
          if (idxQ == LAST) begin
            stateQ <= ST_DONE;
            busyQ  <= 1'b0;
            doneQ  <= 1'b1;
            yQ     <= yD;
            fQ     <= fD;
          end
        end
        default: stateQ <= ST_IDLE;
      endcase
    end
  end

  assign bus.oBusy = busyQ;
  assign bus.oDone = doneQ;
  assign bus.oY    = yQ;
  assign bus.oF    = fQ;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (DATASIZE=8, SLICES=2).
// Build with ALU_SEQ_DAA_EN defined to also exercise the decimal-adjust vectors.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int DATASIZE = 8;
  localparam int SLICES   = 2;
  localparam int W        = DATASIZE * SLICES;
  // Counted from the cycle iStart is presented (cycle 0).
  localparam int LAT      = SLICES + 1;

  logic clock = 1'b0;
  logic iRstN;
`ifdef ALU_SEQ_DAA_EN
  logic iDec;
`endif

  int vectors     = 0;
  int miscompares = 0;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.DATASIZE(DATASIZE), .SLICES(SLICES)) dut (
    .iClk  (clock),
    .iRstN (iRstN),
`ifdef ALU_SEQ_DAA_EN
    .iDec  (iDec),
`endif
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launches one op, scrambles the inputs right after acceptance, then waits
  // a bounded number of cycles for oDone.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cy, output int doneCycle, output int busyCycles);
    @(negedge clock);
    bus.iStart = 1'b1;
    bus.iS     = op;
    bus.iA     = a;
    bus.iB     = b;
    bus.iCy    = cy;
    @(posedge clock);
    #1;
    bus.iStart = 1'b0;
    bus.iS     = ~op;
    bus.iA     = ~a;
    bus.iB     = ~b;
    bus.iCy    = ~cy;
    doneCycle  = -1;
    busyCycles = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (bus.oBusy) busyCycles++;
      if (bus.oDone) begin
        doneCycle = c;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cy,
                       input logic [W-1:0] expY, input logic [7:0] expF);
    int doneCycle;
    int busyCycles;
    applyStimulus(op, a, b, cy, doneCycle, busyCycles);
    checkOutput({tag, "_lat"}, doneCycle, LAT);
    checkOutput({tag, "_busy"}, busyCycles, SLICES);
    checkOutput({tag, "_Y"}, bus.oY, expY);
    checkOutput({tag, "_F"}, bus.oF, expF);
  endtask

  initial begin
    logic [31:0] doneMask;
    logic [31:0] busyMask;
    logic        sawDone;

    iRstN      = 1'b0;
    bus.iStart = 1'b0;
    bus.iS     = 3'b000;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iCy    = 1'b0;
`ifdef ALU_SEQ_DAA_EN
    iDec       = 1'b0;
`endif

    #12;
    checkOutput("rst_busy", bus.oBusy, 0);
    checkOutput("rst_done", bus.oDone, 0);
    checkOutput("rst_Y", bus.oY, 0);
    checkOutput("rst_F", bus.oF, 0);
    @(negedge clock);
    iRstN = 1'b1;

    // Flags: S=0x80 Z=0x40 A=0x10 P=0x04 C=0x01
    runOp("add_00FF", OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 8'h10);
    runOp("sbb_0000", OP_SBB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 8'h95);
    runOp("cmp_eq",   OP_CMP, 16'h1234, 16'h1234, 1'b0, 16'h1234, 8'h44);
    runOp("and_zero", OP_AND, 16'hF0F0, 16'h0F0F, 1'b0, 16'h0000, 8'h54);
    runOp("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 8'h55);
    runOp("add_nocy", OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0002, 8'h00);
    runOp("adc",      OP_ADC, 16'h1234, 16'h4321, 1'b1, 16'h5556, 8'h04);
    runOp("sub_neg",  OP_SUB, 16'h0005, 16'h0006, 1'b1, 16'hFFFF, 8'h95);
    runOp("cmp_lt",   OP_CMP, 16'h0001, 16'h0002, 1'b0, 16'h0001, 8'h95);
    runOp("xor",      OP_XOR, 16'h00FF, 16'h0F0F, 1'b0, 16'h0FF0, 8'h04);
    runOp("or",       OP_OR,  16'h8000, 16'h0001, 1'b0, 16'h8001, 8'h84);

    // iStart held high: dones land on cycles 3,6,9, busy on the cycles between.
    @(negedge clock);
    bus.iStart = 1'b1;
    bus.iS     = OP_ADD;
    bus.iA     = 16'h0001;
    bus.iB     = 16'h0001;
    bus.iCy    = 1'b0;
    doneMask   = '0;
    busyMask   = '0;
    @(posedge clock);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (bus.oDone) doneMask[c] = 1'b1;
      if (bus.oBusy) busyMask[c] = 1'b1;
    end
    bus.iStart = 1'b0;
    checkOutput("b2b_done", doneMask, 32'h0000_0248);
    checkOutput("b2b_busy", busyMask, 32'h0000_01B6);
    checkOutput("b2b_Y", bus.oY, 16'h0002);

    // Reset in the middle of an op: result held while busy, then cleared, no done.
    @(negedge clock);
    bus.iStart = 1'b1;
    bus.iS     = OP_SUB;
    bus.iA     = 16'h0005;
    bus.iB     = 16'h0006;
    @(posedge clock);
    #1;
    bus.iStart = 1'b0;
    @(negedge clock);
    checkOutput("hold_busy", bus.oBusy, 1);
    checkOutput("hold_Y", bus.oY, 16'h0002);
    iRstN = 1'b0;
    #1;
    checkOutput("abort_busy", bus.oBusy, 0);
    checkOutput("abort_done", bus.oDone, 0);
    checkOutput("abort_Y", bus.oY, 0);
    checkOutput("abort_F", bus.oF, 0);
    @(negedge clock);
    @(negedge clock);
    iRstN   = 1'b1;
    sawDone = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (bus.oDone) sawDone = 1'b1;
    end
    checkOutput("abort_nodone", sawDone, 0);
    runOp("post_rst", OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 8'h10);

`ifdef ALU_SEQ_DAA_EN
    iDec = 1'b1;
    runOp("daa_0199", OP_ADD, 16'h0199, 16'h0001, 1'b0, 16'h0200, 8'h10);
    runOp("daa_9999", OP_ADD, 16'h9999, 16'h0001, 1'b0, 16'h0000, 8'h55);
    iDec = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, slice width in bits (multiple of 4, >=8).
REQ-002 SHALL have parameter SLICES, default 2, number of slices per operand (1..8); total width W=DATASIZE*SLICES.
REQ-003 SHALL have port iClk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port iRstN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iStart  input  1  request, sampled only in IDLE or DONE.
REQ-006 SHALL have port iS  input  3  op: 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 AND, 101 XOR, 110 OR, 111 CMP.
REQ-007 SHALL have ports iA, iB  input  W  operands; iCy  input  1  carry/borrow in for ADC/SBB.
REQ-008 SHALL have port oBusy  output  1  high in BUSY.
REQ-009 SHALL have port oDone  output  1  one-cycle pulse when oY/oF are valid.
REQ-010 SHALL have ports oY  output  W  result; oF  output  8  flags S(7) Z(6) A(4) P(2) C(0), other bits 0.

Function
REQ-011 SHALL use states IDLE, BUSY, DONE; IDLE/DONE + iStart -> BUSY; BUSY -> DONE after SLICES slice cycles; DONE -> IDLE if no iStart.
REQ-012 SHALL capture iS, iA, iB, iCy on the accepting edge; later input changes have no effect on the operation in flight.
REQ-013 SHALL process one DATASIZE slice per BUSY cycle, LSB slice first, carry/borrow registered between slices.
REQ-014 SHALL assert oDone exactly SLICES+1 cycles after the accepting edge, for one cycle; oBusy high for exactly SLICES cycles.
REQ-015 SHALL ignore iStart while BUSY (no queueing); iStart in DONE starts back-to-back with no IDLE cycle.
REQ-016 SHALL hold oY/oF from the last completion until the next completion; oY/oF undefined-free (held old value) while BUSY.
REQ-017 SHALL inject iCy into slice 0 only for ADC/SBB; ADD/SUB/CMP use 0.
REQ-018 SHALL set C = final carry-out (ADD/ADC) or final borrow (SUB/SBB/CMP); C=0 for AND/XOR/OR.
REQ-019 SHALL set A = carry/borrow out of bit 3 of slice 0 for arithmetic/CMP; A=1 for AND; A=0 for XOR/OR.
REQ-020 SHALL compute S = oY[W-1], Z = (oY==0) over full W, P = even parity (1 when count of ones even) over full W.
REQ-021 SHALL for CMP leave oY = iA and derive S/Z/P from the internal A-B difference.
REQ-022 SHALL wrap arithmetic modulo 2^W (e.g. all-ones + 1 -> 0, C=1).

Reset
REQ-023 SHALL on iRstN low immediately force IDLE, oBusy=0, oDone=0, oY=0, oF=0, internal carry=0.
REQ-024 SHALL abort any in-flight operation on reset with no oDone; first iStart after release processed normally.

Configuration
REQ-025 SHALL support macro ALU_SEQ_DAA_EN: when defined, add port iDec input 1; with iDec=1 on ADD/ADC each nibble sum >9 or with nibble carry adds 6, decimal carry propagates to next nibble/slice, C=final decimal carry.
REQ-026 SHALL, without ALU_SEQ_DAA_EN, have no iDec port and purely binary behaviour; latency identical in both builds.

Structure
REQ-027 SHALL place op-code constants, flag bit positions and state encodings in shared package alu_pkg.
REQ-028 SHALL instantiate one combinational sub-module alu_slice (one DATASIZE slice: op, a, b, cin -> y, cout, c3) reused every BUSY cycle.

Verification
REQ-029 SHALL test ADD, SLICES=2: A=0x00FF, B=0x0001 -> oY=0x0100, C=0, A=1, Z=0, P=0, oDone at start+3.
REQ-030 SHALL test SBB: A=0x0000, B=0x0000, iCy=1 -> oY=0xFFFF, C=1, S=1, P=1.
REQ-031 SHALL test CMP: A=0x1234, B=0x1234 -> oY=0x1234, Z=1, C=0; AND 0xF0F0&0x0F0F -> oY=0, Z=1, A=1, C=0.
REQ-032 SHALL test iStart held high through BUSY -> only one op per DONE, back-to-back ops each oDone every 3 cycles.
REQ-033 SHALL test iRstN low mid-BUSY -> outputs 0, no oDone; next op completes correctly.
REQ-034 SHALL test (DAA build) ADD iDec=1: 0x0199+0x0001 -> oY=0x0200, C=0; 0x9999+0x0001 -> oY=0x0000, C=1.
